// File: rtl/fpu_dispatch.sv
// fpu_dispatch: request front-end for the private FPU wrapper (riscv_fpu).
// Accepts one FP operation at a time, holds the operands, rounding mode and
// command stable while the FPU is enabled, and returns the result with its
// destination tag over a valid/ready response port. A sticky error flag
// reports FPU protocol violations (late or spurious result_valid).
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   req_*_i / req_ready_o request channel (operands, rm, cmd, tag)
//   fpu_*_o               registered drive to the FPU, plus its enable
//   fpu_result*_i         FPU result and result_valid
//   rsp_*                 response channel (result, tag, valid/ready)
//   busy_o                high while an op is executing or awaiting pickup
//   err_o                 sticky protocol error, cleared only by rst
module fpu_dispatch #(
    parameter int unsigned C_OP    = 32,
    parameter int unsigned C_RM    = 3,
    parameter int unsigned C_CMD   = 4,
    parameter int unsigned C_TAG   = 5,
    parameter int unsigned LATENCY = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [C_OP-1:0]  req_op_a_i,
    input  logic [C_OP-1:0]  req_op_b_i,
    input  logic [C_RM-1:0]  req_rm_i,
    input  logic [C_CMD-1:0] req_cmd_i,
    input  logic [C_TAG-1:0] req_tag_i,
    output logic [C_OP-1:0]  fpu_operand_a_o,
    output logic [C_OP-1:0]  fpu_operand_b_o,
    output logic [C_RM-1:0]  fpu_rm_o,
    output logic [C_CMD-1:0] fpu_operator_o,
    output logic             fpu_enable_o,
    input  logic [C_OP-1:0]  fpu_result_i,
    input  logic             fpu_result_valid_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [C_OP-1:0]  rsp_result_o,
    output logic [C_TAG-1:0] rsp_tag_o,
    output logic             busy_o,
    output logic             err_o
);

    localparam int unsigned      CW      = $clog2(LATENCY + 1);
    localparam logic [CW-1:0]    CNT_MAX = CW'(LATENCY);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        HOLD
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [C_OP-1:0]    op_a_q, op_b_q, result_q;
    logic [C_RM-1:0]    rm_q;
    logic [C_CMD-1:0]   cmd_q;
    logic [C_TAG-1:0]   tag_q, rsp_tag_q;
    logic               err_q;
    logic               load_req, capture, err_set;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        load_req     = 1'b0;
        capture      = 1'b0;
        err_set      = 1'b0;
        fpu_enable_o = 1'b0;
        rsp_valid_o  = 1'b0;
        req_ready_o  = 1'b0;
        unique case (state_q)
            IDLE: begin
                req_ready_o = 1'b1;
                err_set     = fpu_result_valid_i;
                if (req_valid_i) begin
                    load_req = 1'b1;
                    cnt_d    = '0;
                    state_d  = EXEC;
                end
            end
            EXEC: begin
                fpu_enable_o = 1'b1;
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CW'(1);
                end
                if (fpu_result_valid_i) begin
                    capture = 1'b1;
                    state_d = HOLD;
                end else if (cnt_q == CNT_MAX) begin
                    // FPU overran its nominal latency; keep waiting but flag it.
                    err_set = 1'b1;
                end
            end
            HOLD: begin
                rsp_valid_o = 1'b1;
                // A new request may only enter when the held response leaves.
                req_ready_o = rsp_ready_i;
                err_set     = fpu_result_valid_i;
                if (rsp_ready_i) begin
                    if (req_valid_i) begin
                        load_req = 1'b1;
                        cnt_d    = '0;
                        state_d  = EXEC;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            op_a_q    <= '0;
            op_b_q    <= '0;
            rm_q      <= '0;
            cmd_q     <= '0;
            tag_q     <= '0;
            result_q  <= '0;
            rsp_tag_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (load_req) begin
                op_a_q <= req_op_a_i;
                op_b_q <= req_op_b_i;
                rm_q   <= req_rm_i;
                cmd_q  <= req_cmd_i;
                tag_q  <= req_tag_i;
            end
            if (capture) begin
                result_q  <= fpu_result_i;
                rsp_tag_q <= tag_q;
            end
            if (err_set) begin
                err_q <= 1'b1;
            end
        end
    end

    assign fpu_operand_a_o = op_a_q;
    assign fpu_operand_b_o = op_b_q;
    assign fpu_rm_o        = rm_q;
    assign fpu_operator_o  = cmd_q;
    assign rsp_result_o    = result_q;
    assign rsp_tag_o       = rsp_tag_q;
    assign busy_o          = (state_q != IDLE);
    assign err_o           = err_q;

endmodule

// File: tb/tb_fpu_dispatch.sv
// Self-checking bench for fpu_dispatch: a behavioural FPU model answers
// after a programmable number of enabled cycles, and a request/response
// scoreboard checks ordering, data, tags and timing.
module tb_fpu_dispatch;

    localparam int LAT = 2;

    typedef struct {
        logic [4:0]  tag;
        logic [31:0] res;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [31:0] req_op_a_i = '0;
    logic [31:0] req_op_b_i = '0;
    logic [2:0]  req_rm_i = '0;
    logic [3:0]  req_cmd_i = '0;
    logic [4:0]  req_tag_i = '0;
    logic [31:0] fpu_operand_a_o, fpu_operand_b_o;
    logic [2:0]  fpu_rm_o;
    logic [3:0]  fpu_operator_o;
    logic        fpu_enable_o;
    logic [31:0] fpu_result_i = '0;
    logic        fpu_result_valid_i = 1'b0;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b0;
    logic [31:0] rsp_result_o;
    logic [4:0]  rsp_tag_o;
    logic        busy_o, err_o;

    int errors = 0;
    int checks = 0;
    int fpu_delay = LAT;
    int en_cnt = 0;
    bit spurious = 1'b0;

    fpu_dispatch #(.C_OP(32), .C_RM(3), .C_CMD(4), .C_TAG(5), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_op_a_i(req_op_a_i), .req_op_b_i(req_op_b_i),
        .req_rm_i(req_rm_i), .req_cmd_i(req_cmd_i), .req_tag_i(req_tag_i),
        .fpu_operand_a_o(fpu_operand_a_o), .fpu_operand_b_o(fpu_operand_b_o),
        .fpu_rm_o(fpu_rm_o), .fpu_operator_o(fpu_operator_o),
        .fpu_enable_o(fpu_enable_o),
        .fpu_result_i(fpu_result_i), .fpu_result_valid_i(fpu_result_valid_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_result_o(rsp_result_o), .rsp_tag_o(rsp_tag_o),
        .busy_o(busy_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    // Behavioural FPU: 1.0+2.0 for the directed ADD, otherwise a cheap mix.
    function automatic logic [31:0] fpu_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic [3:0] cmd);
        if (cmd == 4'd0 && a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
        return (a ^ (b << cmd)) + {28'd0, cmd};
    endfunction

    // FPU model: result_valid in the fpu_delay-th consecutive enabled cycle.
    always begin
        @(posedge clk);
        #3;
        if (fpu_enable_o) en_cnt++;
        else en_cnt = 0;
        fpu_result_valid_i = spurious || (fpu_enable_o && en_cnt == fpu_delay);
        fpu_result_i = fpu_fn(fpu_operand_a_o, fpu_operand_b_o, fpu_operator_o);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic [31:0] a, input logic [31:0] b, input logic [2:0] rm,
                             input logic [3:0] cmd, input logic [4:0] tag);
        req_valid_i = 1'b1; req_op_a_i = a; req_op_b_i = b;
        req_rm_i = rm; req_cmd_i = cmd; req_tag_i = tag;
    endtask

    task automatic do_reset();
        rst = 1'b1; cyc(); cyc(); rst = 1'b0;
    endtask

    task automatic wait_rsp(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (rsp_valid_o) begin ok = 1'b1; break; end
            cyc();
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (req_ready_o !== 1'b1) begin errors++; $display("FAIL por_ready: got %b expected 1", req_ready_o); end
        checks++; if (fpu_enable_o !== 1'b0) begin errors++; $display("FAIL por_enable: got %b expected 0", fpu_enable_o); end
        checks++; if (rsp_valid_o !== 1'b0) begin errors++; $display("FAIL por_rsp_valid: got %b expected 0", rsp_valid_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL por_busy: got %b expected 0", busy_o); end
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL por_err: got %b expected 0", err_o); end
        // Set err, start an op, then reset mid-EXEC for two cycles.
        spurious = 1'b1; cyc(); spurious = 1'b0;
        drive_req(32'hDEAD_BEEF, 32'h1234_5678, 3'd5, 4'd3, 5'd17);
        cyc(); req_valid_i = 1'b0;
        checks++; if (fpu_enable_o !== 1'b1) begin errors++; $display("FAIL rst_pre_enable: got %b expected 1", fpu_enable_o); end
        rst = 1'b1; cyc(); cyc(); rst = 1'b0;
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy_o); end
        checks++; if (fpu_enable_o !== 1'b0) begin errors++; $display("FAIL rst_enable: got %b expected 0", fpu_enable_o); end
        checks++; if (rsp_valid_o !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid: got %b expected 0", rsp_valid_o); end
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL rst_err: got %b expected 0", err_o); end
        checks++; if (req_ready_o !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b expected 1", req_ready_o); end
        checks++; if (fpu_operand_a_o !== 32'h0) begin errors++; $display("FAIL rst_op_a: got %h expected 0", fpu_operand_a_o); end
        for (int i = 0; i < 4; i++) cyc();
        checks++; if (rsp_valid_o !== 1'b0) begin errors++; $display("FAIL rst_no_rsp: got %b expected 0", rsp_valid_o); end
    endtask

    task automatic test_single_op();
        int en_cycles = 0;
        int rsp_k = -1;
        drive_req(32'h3F80_0000, 32'h4000_0000, 3'd0, 4'd0, 5'd7);
        #1;
        checks++; if (req_ready_o !== 1'b1) begin errors++; $display("FAIL single_ready: got %b expected 1", req_ready_o); end
        cyc(); req_valid_i = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (rsp_valid_o) begin rsp_k = k; break; end
            if (fpu_enable_o) en_cycles++;
            cyc();
        end
        checks++; if (rsp_k !== 2) begin errors++; $display("FAIL single_latency: got %0d expected 2", rsp_k); end
        checks++; if (en_cycles !== 2) begin errors++; $display("FAIL single_enable_cycles: got %0d expected 2", en_cycles); end
        checks++; if (rsp_result_o !== 32'h4040_0000) begin errors++; $display("FAIL single_result: got %h expected 40400000", rsp_result_o); end
        checks++; if (rsp_tag_o !== 5'd7) begin errors++; $display("FAIL single_tag: got %0d expected 7", rsp_tag_o); end
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL single_busy: got %b expected 1", busy_o); end
        rsp_ready_i = 1'b1; cyc(); rsp_ready_i = 1'b0;
        checks++; if (rsp_valid_o !== 1'b0) begin errors++; $display("FAIL single_rsp_drop: got %b expected 0", rsp_valid_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL single_idle: got %b expected 0", busy_o); end
        checks++; if (rsp_result_o !== 32'h4040_0000) begin errors++; $display("FAIL single_result_hold: got %h expected 40400000", rsp_result_o); end
    endtask

    task automatic test_backpressure();
        bit ok;
        logic [31:0] a = $urandom, b = $urandom;
        logic [31:0] exp_res = fpu_fn(a, b, 4'd6);
        drive_req(a, b, 3'd2, 4'd6, 5'd9);
        cyc(); req_valid_i = 1'b0;
        wait_rsp(ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL bp_rsp_timeout: got %b expected 1", ok); end
        for (int i = 0; i < 5; i++) begin
            drive_req($urandom, $urandom, 3'd1, 4'd2, 5'd3);
            #1;
            checks++; if (req_ready_o !== 1'b0) begin errors++; $display("FAIL bp_ready: got %b expected 0", req_ready_o); end
            checks++; if (rsp_valid_o !== 1'b1) begin errors++; $display("FAIL bp_rsp_valid: got %b expected 1", rsp_valid_o); end
            checks++; if (rsp_result_o !== exp_res) begin errors++; $display("FAIL bp_result: got %h expected %h", rsp_result_o, exp_res); end
            checks++; if (rsp_tag_o !== 5'd9) begin errors++; $display("FAIL bp_tag: got %0d expected 9", rsp_tag_o); end
            checks++; if (fpu_enable_o !== 1'b0) begin errors++; $display("FAIL bp_enable: got %b expected 0", fpu_enable_o); end
            cyc();
        end
        req_valid_i = 1'b0; rsp_ready_i = 1'b1; cyc(); rsp_ready_i = 1'b0;
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL bp_idle: got %b expected 0", busy_o); end
    endtask

    task automatic test_back_to_back();
        int          seen_k[$];
        logic [4:0]  seen_tag[$];
        logic [31:0] seen_res[$];
        logic [31:0] a1 = $urandom, b1 = $urandom, a2 = $urandom, b2 = $urandom;
        rsp_ready_i = 1'b1;
        drive_req(a1, b1, 3'd1, 4'd4, 5'd1);
        cyc();
        drive_req(a2, b2, 3'd3, 4'd9, 5'd2);
        for (int k = 0; k < 10; k++) begin
            #1;
            if (k == 2) begin
                checks++; if (req_ready_o !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b expected 1", req_ready_o); end
            end
            if (k == 3) begin
                checks++; if (fpu_enable_o !== 1'b1) begin errors++; $display("FAIL b2b_reenable: got %b expected 1", fpu_enable_o); end
            end
            if (rsp_valid_o) begin
                seen_k.push_back(k); seen_tag.push_back(rsp_tag_o); seen_res.push_back(rsp_result_o);
            end
            cyc();
            if (k == 2) req_valid_i = 1'b0;
        end
        rsp_ready_i = 1'b0;
        checks++; if (seen_k.size() !== 2) begin errors++; $display("FAIL b2b_count: got %0d expected 2", seen_k.size()); end
        if (seen_k.size() == 2) begin
            checks++; if (seen_k[0] !== 2) begin errors++; $display("FAIL b2b_t1: got %0d expected 2", seen_k[0]); end
            checks++; if (seen_k[1] !== 5) begin errors++; $display("FAIL b2b_t2: got %0d expected 5", seen_k[1]); end
            checks++; if (seen_tag[0] !== 5'd1) begin errors++; $display("FAIL b2b_tag1: got %0d expected 1", seen_tag[0]); end
            checks++; if (seen_tag[1] !== 5'd2) begin errors++; $display("FAIL b2b_tag2: got %0d expected 2", seen_tag[1]); end
            checks++; if (seen_res[0] !== fpu_fn(a1, b1, 4'd4)) begin errors++; $display("FAIL b2b_res1: got %h expected %h", seen_res[0], fpu_fn(a1, b1, 4'd4)); end
            checks++; if (seen_res[1] !== fpu_fn(a2, b2, 4'd9)) begin errors++; $display("FAIL b2b_res2: got %h expected %h", seen_res[1], fpu_fn(a2, b2, 4'd9)); end
        end
    endtask

    task automatic test_operand_stability();
        bit ok;
        int n = 0;
        logic [31:0] a0 = $urandom, b0 = $urandom;
        drive_req(a0, b0, 3'd6, 4'd11, 5'd21);
        cyc(); req_valid_i = 1'b0;
        while (fpu_enable_o && n < 10) begin
            req_op_a_i = $urandom; req_op_b_i = $urandom; req_rm_i = 3'($urandom); req_cmd_i = 4'($urandom);
            #1;
            checks++; if (fpu_operand_a_o !== a0) begin errors++; $display("FAIL stab_op_a: got %h expected %h", fpu_operand_a_o, a0); end
            checks++; if (fpu_operand_b_o !== b0) begin errors++; $display("FAIL stab_op_b: got %h expected %h", fpu_operand_b_o, b0); end
            checks++; if (fpu_rm_o !== 3'd6) begin errors++; $display("FAIL stab_rm: got %0d expected 6", fpu_rm_o); end
            checks++; if (fpu_operator_o !== 4'd11) begin errors++; $display("FAIL stab_cmd: got %0d expected 11", fpu_operator_o); end
            n++;
            cyc();
        end
        checks++; if (n !== LAT) begin errors++; $display("FAIL stab_exec_cycles: got %0d expected %0d", n, LAT); end
        wait_rsp(ok);
        checks++; if (rsp_result_o !== fpu_fn(a0, b0, 4'd11)) begin errors++; $display("FAIL stab_result: got %h expected %h", rsp_result_o, fpu_fn(a0, b0, 4'd11)); end
        rsp_ready_i = 1'b1; cyc(); rsp_ready_i = 1'b0;
    endtask

    task automatic test_protocol_error();
        logic [31:0] a = $urandom, b = $urandom;
        do_reset();
        fpu_delay = 5;
        drive_req(a, b, 3'd0, 4'd1, 5'd12);
        cyc(); req_valid_i = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (k == 1) begin
                checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL perr_early: got %b expected 0", err_o); end
            end
            if (k == 4) begin
                checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL perr_late: got %b expected 1", err_o); end
            end
            if (rsp_valid_o) break;
            cyc();
        end
        checks++; if (rsp_valid_o !== 1'b1) begin errors++; $display("FAIL perr_rsp: got %b expected 1", rsp_valid_o); end
        checks++; if (rsp_result_o !== fpu_fn(a, b, 4'd1)) begin errors++; $display("FAIL perr_result: got %h expected %h", rsp_result_o, fpu_fn(a, b, 4'd1)); end
        rsp_ready_i = 1'b1; cyc(); rsp_ready_i = 1'b0; cyc(); cyc();
        fpu_delay = LAT;
        checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL perr_sticky: got %b expected 1", err_o); end
        do_reset();
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL perr_clear: got %b expected 0", err_o); end
        spurious = 1'b1; cyc(); spurious = 1'b0;
        checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL perr_spurious: got %b expected 1", err_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL perr_spurious_idle: got %b expected 0", busy_o); end
        do_reset();
    endtask

    task automatic test_random();
        exp_t q[$];
        exp_t e;
        int   guard = 0;
        for (int c = 0; c < 400; c++) begin
            if (!fpu_enable_o) fpu_delay = $urandom_range(1, LAT);
            if (c < 360) begin
                req_valid_i = ($urandom_range(0, 2) != 0);
                req_op_a_i = $urandom; req_op_b_i = $urandom;
                req_rm_i = 3'($urandom); req_cmd_i = 4'($urandom); req_tag_i = 5'($urandom);
                rsp_ready_i = 1'($urandom_range(0, 1));
            end else begin
                req_valid_i = 1'b0; rsp_ready_i = 1'b1;
            end
            #1;
            checks++; if (busy_o !== (q.size() != 0)) begin errors++; $display("FAIL rnd_busy: got %b expected %b", busy_o, q.size() != 0); end
            if (rsp_valid_o && rsp_ready_i) begin
                if (q.size() == 0) begin
                    checks++; errors++; $display("FAIL rnd_unexpected_rsp: got tag %0d expected none", rsp_tag_o);
                end else begin
                    e = q.pop_front();
                    checks++; if (rsp_tag_o !== e.tag) begin errors++; $display("FAIL rnd_tag: got %0d expected %0d", rsp_tag_o, e.tag); end
                    checks++; if (rsp_result_o !== e.res) begin errors++; $display("FAIL rnd_result: got %h expected %h", rsp_result_o, e.res); end
                end
            end
            if (req_valid_i && req_ready_o) begin
                e.tag = req_tag_i;
                e.res = fpu_fn(req_op_a_i, req_op_b_i, req_cmd_i);
                q.push_back(e);
            end
            cyc();
            guard = c;
        end
        checks++; if (q.size() !== 0) begin errors++; $display("FAIL rnd_drain: got %0d pending expected 0 after %0d cycles", q.size(), guard + 1); end
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL rnd_err: got %b expected 0", err_o); end
        rsp_ready_i = 1'b0;
        fpu_delay = LAT;
    endtask

    initial begin
        test_reset();
        test_single_op();
        test_backpressure();
        test_back_to_back();
        test_operand_stability();
        test_protocol_error();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
